// File: rtl/reg_byte_reader.sv
`default_nettype none
// ============================================================================
// Module  : reg_byte_reader
// Purpose : Reads one word from a register (one-cycle r_en strobe, fixed
//           read latency), then streams the word out LSB-first as BYTE_W-wide
//           beats over a valid/ready handshake and pulses done.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           start           - begin a transaction (sampled only in IDLE)
//           busy            - high whenever not IDLE
//           r_en            - one-cycle read strobe to the register
//           rd_data         - register read data
//           byte_out/valid  - current beat and its valid flag
//           byte_ready      - consumer accepts the current beat
//           done            - one-cycle pulse after the last accepted beat
// Revision: 1.0 - initial release
// ============================================================================
module reg_byte_reader #(
    parameter int DATA_W   = 32,
    parameter int BYTE_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              r_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              done
);

    localparam int N      = DATA_W / BYTE_W;
    localparam int BCNT_W = (N > 1) ? $clog2(N) : 1;
    // READ_LAT+1 keeps the width at least one bit when READ_LAT is 1.
    localparam int WCNT_W = $clog2(READ_LAT + 1);

    localparam logic [BCNT_W-1:0] C_BEAT_LAST = BCNT_W'(N - 1);
    localparam logic [WCNT_W-1:0] C_WAIT_LAST = WCNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [DATA_W-1:0]   r_shreg;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic [WCNT_W-1:0]   r_wait_cnt;

    logic w_last_wait;
    logic w_accept;
    logic w_last_beat;

    assign w_last_wait = (r_state == S_WAIT) && (r_wait_cnt == C_WAIT_LAST);
    // byte_valid is exactly "in SEND", so the handshake reduces to this.
    assign w_accept    = (r_state == S_SEND) && byte_ready;
    assign w_last_beat = w_accept && (r_beat_cnt == C_BEAT_LAST);

    // Next-state and output decode; every output depends on registered state
    // only, so nothing combinational reaches an output from start/byte_ready.
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b1;
        r_en       = 1'b0;
        byte_valid = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nx = S_REQ;
            end
            S_REQ: begin
                r_en       = 1'b1;
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_last_wait) w_state_nx = S_SEND;
            end
            S_SEND: begin
                byte_valid = 1'b1;
                if (w_last_beat) w_state_nx = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // The shift register empties itself as beats drain, so byte_out is zero
    // whenever no beat is being presented.
    assign byte_out = r_shreg[BYTE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nx;

            if (r_state == S_REQ) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end

            if (w_last_wait) begin
                r_shreg    <= rd_data;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_shreg    <= r_shreg >> BYTE_W;
                r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_byte_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_byte_reader
// Purpose : Self-checking bench for reg_byte_reader. Two instances: one with
//           READ_LAT=1 and one with READ_LAT=3, selected through a mux.
//           Expected beats are the word's bytes LSB-first; expected timing
//           comes from the cycle formulas of the transaction.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_byte_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        byte_ready = 1'b0;
    logic [31:0] rd_a = '0;
    logic [31:0] rd_b = '0;
    logic        sel = 1'b0;

    logic       busy_a, r_en_a, valid_a, done_a;
    logic       busy_b, r_en_b, valid_b, done_b;
    logic [7:0] byte_a, byte_b;

    logic       o_busy, o_r_en, o_valid, o_done;
    logic [7:0] o_byte;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_byte_reader #(.DATA_W(32), .BYTE_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .r_en(r_en_a),
        .rd_data(rd_a), .byte_out(byte_a), .byte_valid(valid_a),
        .byte_ready(byte_ready), .done(done_a)
    );

    reg_byte_reader #(.DATA_W(32), .BYTE_W(8), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .r_en(r_en_b),
        .rd_data(rd_b), .byte_out(byte_b), .byte_valid(valid_b),
        .byte_ready(byte_ready), .done(done_b)
    );

    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_r_en  = sel ? r_en_b  : r_en_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_byte  = sel ? byte_b  : byte_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // One transaction. mode: 0 ready high, 1 ready pattern 1,0,0,1,0,1,1
    // from the first valid cycle, 2 random ready. poke re-pulses start in
    // WAIT and in SEND. abort_after>0 resets right after that many beats.
    task automatic txn(input logic [31:0] word, input int mode, input bit poke,
                       input int abort_after);
        int         lat = sel ? 3 : 1;
        int         cyc = 0;
        int         ren_cnt = 0;
        int         ren_cyc = -1;
        int         first_v = -1;
        int         hs = 0;
        int         last_hs = -1;
        int         done_cyc = -1;
        int         pat_i = 0;
        int         quiet = 0;
        logic [6:0] pat = 7'b1101001;
        logic [7:0] exp_b [4];
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pb = '0;
        bit         fin = 1'b0;
        for (int i = 0; i < 4; i++) exp_b[i] = 8'((word >> (8 * i)) & 32'hFF);
        if (sel) rd_b = 32'h1111_1111; else rd_a = word;
        drive_start(1'b1);
        while (!fin && cyc < 80) begin
            tick();
            cyc++;
            drive_start(1'b0);
            if (poke && (cyc == 2 || cyc == lat + 3)) drive_start(1'b1);
            if (o_r_en) begin
                ren_cnt++;
                if (ren_cyc < 0) ren_cyc = cyc;
            end
            if (sel && ren_cyc >= 0 && cyc == ren_cyc + 3) rd_b = word;
            if (sel && ren_cyc >= 0 && cyc == ren_cyc + 4) rd_b = 32'hFFFF_FFFF;
            if (o_valid && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                chk("stable_valid", 32'(o_valid), 32'd1);
                chk("stable_byte", 32'(o_byte), 32'(pb));
            end
            if (o_done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            case (mode)
                0: byte_ready = 1'b1;
                1: begin
                    if (first_v >= 0) begin
                        byte_ready = pat[pat_i % 7];
                        pat_i++;
                    end else begin
                        byte_ready = 1'b0;
                    end
                end
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            if (o_valid && byte_ready) begin
                hs++;
                last_hs = cyc;
                if (hs <= 4) chk("beat", 32'(o_byte), 32'(exp_b[hs-1]));
            end
            pv = o_valid;
            pr = byte_ready;
            pb = o_byte;
            if (abort_after > 0 && hs == abort_after && !fin) begin
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_valid", 32'(o_valid), 32'd0);
                chk("abort_busy", 32'(o_busy), 32'd0);
                chk("abort_byte", 32'(o_byte), 32'd0);
                chk("abort_done", 32'(o_done), 32'd0);
                repeat (8) begin
                    tick();
                    if (o_done || o_valid || o_busy) quiet++;
                end
                chk("abort_quiet", quiet, 0);
                return;
            end
        end
        chk("timeout_done_seen", 32'(fin), 32'd1);
        chk("ren_count", ren_cnt, 1);
        chk("ren_cycle", ren_cyc, 1);
        chk("first_valid_cycle", first_v, lat + 2);
        chk("beat_count", hs, 4);
        chk("done_after_last_hs", done_cyc, last_hs + 1);
        if (mode == 0) chk("done_cycle", done_cyc, lat + 6);
        tick();
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_valid", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int ren_q[$];
        int beats;
        int dones;
        int bad;
        logic [31:0] w;

        // Reset held with start asserted: reset must win.
        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_r_en", 32'(r_en_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_byte", 32'(byte_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy_a), 32'd0);

        sel = 1'b0;
        txn(32'hDEAD_BEEF, 0, 1'b0, 0);
        txn(32'h1234_5678, 1, 1'b0, 0);
        txn($urandom, 0, 1'b1, 0);
        txn($urandom, 1, 1'b1, 0);
        txn(32'hCAFE_F00D, 0, 1'b0, 2);
        txn(32'hCAFE_F00D, 0, 1'b0, 0);

        sel = 1'b1;
        txn(32'hA5A5_A5A5, 0, 1'b0, 0);
        txn($urandom, 2, 1'b1, 0);

        sel = 1'b0;
        for (int k = 0; k < 4; k++) txn($urandom, 2, 1'($urandom_range(0, 1)), 0);

        // Back-to-back with start held high: period L+N+3 = 8 cycles.
        w = $urandom;
        rd_a = w;
        byte_ready = 1'b1;
        start_a = 1'b1;
        beats = 0;
        dones = 0;
        bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 40) start_a = 1'b0;
            if (r_en_a) ren_q.push_back(c);
            if (valid_a) begin
                if (byte_a !== 8'((w >> (8 * (beats % 4))) & 32'hFF)) bad++;
                beats++;
            end
            if (done_a) dones++;
        end
        chk("b2b_ren_count", ren_q.size(), 5);
        for (int i = 0; i < ren_q.size(); i++) chk("b2b_ren_cycle", ren_q[i], 1 + 8 * i);
        chk("b2b_beats", beats, 20);
        chk("b2b_dones", dones, 5);
        chk("b2b_beat_values", bad, 0);
        repeat (3) tick();
        chk("b2b_final_idle", 32'(busy_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
